mkio_bc_tx_sequencer: RTL and testbench
=======================================

Name: mkio_bc_tx_sequencer

Overview:
- Bus-controller transmit sequencer for the MKIO (MIL-STD-1553) link. It owns the handshake of the single Manchester word transmitter (imp_send / cd_send / data_send / busy_send).
- For each message it sends one command word, then the data words the command calls for, taken from an internal host-loaded buffer.
- It reports completion, abort status and the count of words sent to the host-side control logic.

Parameters:
- DEPTH, 32, data-word buffer depth in 16-bit words; fixed by the 1553 maximum, must be 32.
- AW, 5, buffer address width, clog2(DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write address
- wr_data  in  16  buffer write data
- start  in  1  one-cycle request to send a message
- cmd_word  in  16  command word, sampled when start is accepted
- abort  in  1  one-cycle request to stop the message at the next word boundary
- imp_send  out  1  one-cycle load strobe to the transmitter
- cd_send  out  1  word type to the transmitter: 1 = command sync, 0 = data sync
- data_send  out  16  word to the transmitter
- busy_send  in  1  transmitter busy flag
- seq_busy  out  1  message in progress
- done  out  1  one-cycle pulse at message end
- aborted  out  1  status of the last message: 1 = ended by abort; valid from the done pulse until the next start
- words_sent  out  6  words handed to the transmitter in the current or last message (0..33)

Behaviour:
- Reset values: imp_send=0, cd_send=0, data_send=0, seq_busy=0, done=0, aborted=0, words_sent=0, state=IDLE. Buffer contents are not reset.
- Buffer
  - Synchronous write when wr_en=1, allowed in any state.
  - Read is registered into data_send.
  - Write and read of the same address in the same cycle returns the old value.
- Word count decode from the latched command
  - n = cmd[4:0], with 0 meaning 32.
  - If cmd[10] (T/R) = 1, this is an RT-transmit command: data words = 0.
  - Total words = 1 + data words.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_TX, FIN.
- IDLE
  - start=1 and busy_send=0: latch cmd_word; idx=0; words_sent=0; aborted=0; seq_busy=1; go to ISSUE.
  - start while busy_send=1 or seq_busy=1 is ignored (dropped, no queueing).
- ISSUE (one cycle)
  - imp_send=1 registered, held for exactly one clk.
  - First word of the message: cd_send=1, data_send=cmd.
  - Later words: cd_send=0, data_send=buf[idx].
  - words_sent increments; go to WAIT_ACK.
- WAIT_ACK: wait for busy_send=1, then go to WAIT_TX.
- WAIT_TX
  - On busy_send=0: if the abort flag is set or all words have been sent, go to FIN.
  - Otherwise idx++ (when a data word was sent) and go to ISSUE.
  - Gap: busy_send sampled low at edge t gives imp_send high after edge t+1.
- FIN: done=1 for one cycle; seq_busy=0 at the same edge; go to IDLE.
- Output holds
  - cd_send and data_send hold their values between imp_send pulses.
  - imp_send=0 in every state except ISSUE.
- abort
  - Sampled in any non-IDLE state and sets a sticky flag.
  - The word already handed to the transmitter completes; no further imp_send is issued.
  - aborted=1 is reported with done.
  - abort in IDLE is ignored.
  - abort in the ISSUE cycle still lets that word complete.
- Reset mid-message returns to IDLE at once with no done pulse. The transmitter is reset by the same signal.
- words_sent saturates naturally at 33; idx never exceeds 31.

Test Plan:
- Load buf[0]=16'hA5A5, buf[1]=16'h0F0F; start with cmd_word=16'h0802 (T/R=0, count=2) -> three imp_send pulses:
  - cd/data = 1/0802, 0/A5A5, 0/0F0F;
  - each pulse follows busy_send falling (2 clk later);
  - done, words_sent=3, aborted=0.
- cmd_word=16'h0C03 (T/R=1) -> a single pulse with cd_send=1; done after busy_send falls; words_sent=1.
- cmd_word=16'h0800 (count 0) -> 33 pulses; buffer addresses 0..31 sent in order; words_sent=33.
- cmd 16'h0805; abort during the second word -> the second word completes, no third pulse, done with aborted=1, words_sent=2.
- start pulsed while seq_busy=1, and again while busy_send=1 in IDLE -> both ignored; no imp_send and no state change.
- Assert reset during WAIT_TX of a 4-word message -> all outputs return to reset values immediately; no done; the next start runs normally.

Source files
------------

// File: rtl/mkio_bc_tx_sequencer.sv
// MKIO (MIL-STD-1553) bus-controller transmit sequencer: sends one command word
// and then the data words it calls for, from a host-loaded 32-word buffer.
module mkio_bc_tx_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic [15:0]   cmd_word,
  input  logic          abort,
  output logic          imp_send,
  output logic          cd_send,
  output logic [15:0]   data_send,
  input  logic          busy_send,
  output logic          seq_busy,
  output logic          done,
  output logic          aborted,
  output logic [5:0]    words_sent
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_WAIT_TX  = 3'd3;
  localparam logic [2:0] S_FIN      = 3'd4;

  logic [15:0]   mem_q [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [5:0]    words_q, words_d;
  logic          abort_flag_q, abort_flag_d;
  logic          aborted_q, aborted_d;
  logic          seq_busy_q, seq_busy_d;
  logic          done_q, done_d;
  logic          imp_q, imp_d;
  logic          cd_q, cd_d;
  logic [15:0]   data_q, data_d;

  logic [5:0]    data_words;
  logic [5:0]    total_words;

  // Buffer contents survive reset so the host can preload before a message.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A word count field of zero means 32; an RT-transmit command carries no data.
  assign data_words  = cmd_q[10] ? 6'd0
                     : ((cmd_q[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd_q[4:0]});
  assign total_words = data_words + 6'd1;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    words_d      = words_q;
    abort_flag_d = abort_flag_q;
    aborted_d    = aborted_q;
    seq_busy_d   = seq_busy_q;
    done_d       = 1'b0;
    imp_d        = 1'b0;
    cd_d         = cd_q;
    data_d       = data_q;

    if ((state_q != S_IDLE) && abort) begin
      abort_flag_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !busy_send && !seq_busy_q) begin
          cmd_d        = cmd_word;
          idx_d        = '0;
          words_d      = 6'd0;
          abort_flag_d = 1'b0;
          aborted_d    = 1'b0;
          seq_busy_d   = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        imp_d = 1'b1;
        if (words_q == 6'd0) begin
          cd_d   = 1'b1;
          data_d = cmd_q;
        end else begin
          cd_d   = 1'b0;
          data_d = mem_q[idx_q];
        end
        words_d = words_q + 6'd1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (busy_send) begin
          state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (!busy_send) begin
          if (abort_flag_q || abort || (words_q == total_words)) begin
            state_d = S_FIN;
          end else begin
            // The buffer pointer only moves once a data word (not the command) went out.
            if (words_q > 6'd1) begin
              idx_d = idx_q + 1'b1;
            end
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        done_d     = 1'b1;
        seq_busy_d = 1'b0;
        aborted_d  = abort_flag_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= 16'h0000;
      idx_q        <= '0;
      words_q      <= 6'd0;
      abort_flag_q <= 1'b0;
      aborted_q    <= 1'b0;
      seq_busy_q   <= 1'b0;
      done_q       <= 1'b0;
      imp_q        <= 1'b0;
      cd_q         <= 1'b0;
      data_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      words_q      <= words_d;
      abort_flag_q <= abort_flag_d;
      aborted_q    <= aborted_d;
      seq_busy_q   <= seq_busy_d;
      done_q       <= done_d;
      imp_q        <= imp_d;
      cd_q         <= cd_d;
      data_q       <= data_d;
    end
  end

  assign imp_send   = imp_q;
  assign cd_send    = cd_q;
  assign data_send  = data_q;
  assign seq_busy   = seq_busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_mkio_bc_tx_sequencer.sv
// Directed bench for mkio_bc_tx_sequencer with a simple transmitter model that
// logs every word handed over and holds busy_send for a fixed word time.
module tb_mkio_bc_tx_sequencer;

  localparam int TX_LEN = 4;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [15:0] cmd_word;
  logic        abort;
  logic        imp_send;
  logic        cd_send;
  logic [15:0] data_send;
  logic        busy_send;
  logic        seq_busy;
  logic        done;
  logic        aborted;
  logic [5:0]  words_sent;

  logic        model_busy;
  logic        force_busy;
  assign busy_send = model_busy | force_busy;

  int          pass_cnt;
  int          total_cnt;
  int          cyc;
  int          fall_cyc;
  int          done_cnt;
  logic        log_cd [$];
  logic [15:0] log_data [$];
  int          log_gap [$];

  mkio_bc_tx_sequencer #(.DEPTH(32), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .cmd_word   (cmd_word),
    .abort      (abort),
    .imp_send   (imp_send),
    .cd_send    (cd_send),
    .data_send  (data_send),
    .busy_send  (busy_send),
    .seq_busy   (seq_busy),
    .done       (done),
    .aborted    (aborted),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model, sampled on the falling edge.
  initial begin
    model_busy = 1'b0;
    cyc        = 0;
    fall_cyc   = 0;
    done_cnt   = 0;
    begin : model_loop
      int cnt;
      cnt = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
          model_busy = 1'b0;
          cnt        = 0;
        end else begin
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              model_busy = 1'b0;
              fall_cyc   = cyc;
            end
          end
          if (imp_send) begin
            log_cd.push_back(cd_send);
            log_data.push_back(data_send);
            log_gap.push_back(cyc - fall_cyc);
            model_busy = 1'b1;
            cnt        = TX_LEN;
          end
          if (done) done_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_cd.delete();
    log_data.delete();
    log_gap.delete();
  endtask

  task automatic buf_write(input logic [4:0] a, input logic [15:0] d);
    step();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] c);
    step();
    start    = 1'b1;
    cmd_word = c;
    step();
    start    = 1'b0;
    cmd_word = 16'hFFFF;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (log_cd.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total_cnt++;
    if ({imp_send, cd_send, data_send, seq_busy, done, aborted, words_sent} !== 23'd0) begin
      $display("FAIL reset_outputs: got imp=%b cd=%b data=%h busy=%b done=%b ab=%b ws=%0d, want all 0",
               imp_send, cd_send, data_send, seq_busy, done, aborted, words_sent);
    end else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if ({imp_send, seq_busy, words_sent} !== 8'd0) begin
      $display("FAIL reset_release: got imp=%b busy=%b ws=%0d, want 0/0/0", imp_send, seq_busy, words_sent);
    end else pass_cnt++;
    $display("reset: released");
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    logic [15:0] exp_data [3];
    logic        exp_cd [3];
    exp_data[0] = 16'h0802; exp_cd[0] = 1'b1;
    exp_data[1] = 16'hA5A5; exp_cd[1] = 1'b0;
    exp_data[2] = 16'h0F0F; exp_cd[2] = 1'b0;
    buf_write(5'd0, 16'hA5A5);
    buf_write(5'd1, 16'h0F0F);
    clear_log();
    d0 = done_cnt;
    pulse_start(16'h0802);
    total_cnt++;
    if (seq_busy !== 1'b1) $display("FAIL basic_seq_busy: got %b want 1", seq_busy);
    else pass_cnt++;
    wait_done(200, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_done_timeout: got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (log_cd.size() !== 3) $display("FAIL basic_count: got %0d pulses want 3", log_cd.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < log_cd.size(); i++) begin
      total_cnt++;
      if ({log_cd[i], log_data[i]} !== {exp_cd[i], exp_data[i]})
        $display("FAIL basic_word%0d: got %b/%h want %b/%h", i, log_cd[i], log_data[i], exp_cd[i], exp_data[i]);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (log_gap[i] !== 2) $display("FAIL basic_gap%0d: got %0d want 2", i, log_gap[i]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({words_sent, aborted, seq_busy} !== {6'd3, 1'b0, 1'b0})
      $display("FAIL basic_status: got ws=%0d ab=%b busy=%b want 3/0/0", words_sent, aborted, seq_busy);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
    else pass_cnt++;
    $display("basic: cmd=0802 words=%0d ws=%0d aborted=%b", log_cd.size(), words_sent, aborted);
  endtask

  task automatic test_rt_transmit();
    bit ok;
    clear_log();
    pulse_start(16'h0C03);
    wait_done(200, ok);
    total_cnt++;
    if (!ok) $display("FAIL rt_done_timeout: got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (log_cd.size() !== 1) $display("FAIL rt_count: got %0d pulses want 1", log_cd.size());
    else pass_cnt++;
    if (log_cd.size() > 0) begin
      total_cnt++;
      if ({log_cd[0], log_data[0]} !== {1'b1, 16'h0C03})
        $display("FAIL rt_word: got %b/%h want 1/0c03", log_cd[0], log_data[0]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({words_sent, aborted} !== {6'd1, 1'b0})
      $display("FAIL rt_status: got ws=%0d ab=%b want 1/0", words_sent, aborted);
    else pass_cnt++;
    $display("rt_transmit: cmd=0c03 words=%0d ws=%0d", log_cd.size(), words_sent);
  endtask

  task automatic test_count_zero();
    bit ok;
    int bad;
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = 16'h5A00 + 16'(i);
      buf_write(5'(i), w);
    end
    clear_log();
    pulse_start(16'h0800);
    wait_done(1500, ok);
    total_cnt++;
    if (!ok) $display("FAIL cnt0_done_timeout: got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (log_cd.size() !== 33) $display("FAIL cnt0_count: got %0d pulses want 33", log_cd.size());
    else pass_cnt++;
    if (log_cd.size() > 0) begin
      total_cnt++;
      if ({log_cd[0], log_data[0]} !== {1'b1, 16'h0800})
        $display("FAIL cnt0_cmd: got %b/%h want 1/0800", log_cd[0], log_data[0]);
      else pass_cnt++;
    end
    for (int i = 1; i < 33 && i < log_cd.size(); i++) begin
      logic [15:0] w;
      w = 16'h5A00 + 16'(i - 1);
      total_cnt++;
      if ({log_cd[i], log_data[i]} !== {1'b0, w})
        $display("FAIL cnt0_word%0d: got %b/%h want 0/%h", i, log_cd[i], log_data[i], w);
      else pass_cnt++;
    end
    bad = 0;
    for (int i = 1; i < log_gap.size(); i++) if (log_gap[i] != 2) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL cnt0_gaps: got %0d wrong gaps want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (words_sent !== 6'd33) $display("FAIL cnt0_words_sent: got %0d want 33", words_sent);
    else pass_cnt++;
    $display("count_zero: cmd=0800 words=%0d ws=%0d", log_cd.size(), words_sent);
  endtask

  task automatic test_abort();
    bit ok;
    clear_log();
    pulse_start(16'h0805);
    wait_log(2, 200, ok);
    total_cnt++;
    if (!ok) $display("FAIL abort_second_word_timeout: got %0d pulses want 2", log_cd.size());
    else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_done(200, ok);
    total_cnt++;
    if (!ok) $display("FAIL abort_done_timeout: got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (log_cd.size() !== 2) $display("FAIL abort_count: got %0d pulses want 2", log_cd.size());
    else pass_cnt++;
    if (log_cd.size() > 1) begin
      total_cnt++;
      if ({log_cd[1], log_data[1]} !== {1'b0, 16'h5A00})
        $display("FAIL abort_word1: got %b/%h want 0/5a00", log_cd[1], log_data[1]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({words_sent, aborted} !== {6'd2, 1'b1})
      $display("FAIL abort_status: got ws=%0d ab=%b want 2/1", words_sent, aborted);
    else pass_cnt++;
    // Abort while idle has no effect on the reported status.
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({aborted, seq_busy, words_sent} !== {1'b1, 1'b0, 6'd2})
      $display("FAIL abort_idle: got ab=%b busy=%b ws=%0d want 1/0/2", aborted, seq_busy, words_sent);
    else pass_cnt++;
    $display("abort: cmd=0805 words=%0d ws=%0d aborted=%b", log_cd.size(), words_sent, aborted);
  endtask

  task automatic test_ignored_start();
    bit ok;
    int n0;
    clear_log();
    pulse_start(16'h0802);
    total_cnt++;
    if (aborted !== 1'b0) $display("FAIL ign_aborted_cleared: got %b want 0", aborted);
    else pass_cnt++;
    wait_log(1, 50, ok);
    pulse_start(16'h0C01);
    wait_done(200, ok);
    total_cnt++;
    if (!ok) $display("FAIL ign_done_timeout: got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (log_cd.size() !== 3) $display("FAIL ign_busy_count: got %0d pulses want 3", log_cd.size());
    else pass_cnt++;
    if (log_cd.size() > 2) begin
      total_cnt++;
      if ({log_data[0], log_data[2]} !== {16'h0802, 16'h5A01})
        $display("FAIL ign_busy_words: got %h,%h want 0802,5a01", log_data[0], log_data[2]);
      else pass_cnt++;
    end
    repeat (2) step();
    force_busy = 1'b1;
    n0 = log_cd.size();
    pulse_start(16'h0C01);
    repeat (6) step();
    total_cnt++;
    if ({log_cd.size() == n0, seq_busy, words_sent} !== {1'b1, 1'b0, 6'd3})
      $display("FAIL ign_txbusy: got pulses=%0d busy=%b ws=%0d want %0d/0/3",
               log_cd.size(), seq_busy, words_sent, n0);
    else pass_cnt++;
    force_busy = 1'b0;
    repeat (4) step();
    total_cnt++;
    if ({log_cd.size() == n0, seq_busy} !== 2'b10)
      $display("FAIL ign_no_queue: got pulses=%0d busy=%b want %0d/0", log_cd.size(), seq_busy, n0);
    else pass_cnt++;
    $display("ignored_start: pulses=%0d ws=%0d", log_cd.size(), words_sent);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    clear_log();
    pulse_start(16'h0803);
    wait_log(2, 100, ok);
    total_cnt++;
    if (!ok) $display("FAIL rmid_progress_timeout: got %0d pulses want 2", log_cd.size());
    else pass_cnt++;
    step();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({imp_send, cd_send, data_send, seq_busy, done, aborted, words_sent} !== 23'd0)
      $display("FAIL rmid_outputs: got imp=%b cd=%b data=%h busy=%b done=%b ab=%b ws=%0d want all 0",
               imp_send, cd_send, data_send, seq_busy, done, aborted, words_sent);
    else pass_cnt++;
    repeat (2) step();
    reset = 1'b0;
    repeat (4) step();
    total_cnt++;
    if ((done_cnt - d0) !== 0 || seq_busy !== 1'b0)
      $display("FAIL rmid_no_done: got done_pulses=%0d busy=%b want 0/0", done_cnt - d0, seq_busy);
    else pass_cnt++;
    clear_log();
    pulse_start(16'h0802);
    wait_done(200, ok);
    total_cnt++;
    if (!ok) $display("FAIL rmid_rerun_timeout: got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (log_cd.size() !== 3 || words_sent !== 6'd3 || aborted !== 1'b0)
      $display("FAIL rmid_rerun: got pulses=%0d ws=%0d ab=%b want 3/3/0", log_cd.size(), words_sent, aborted);
    else pass_cnt++;
    if (log_cd.size() > 1) begin
      total_cnt++;
      if ({log_cd[1], log_data[1]} !== {1'b0, 16'h5A00})
        $display("FAIL rmid_rerun_word1: got %b/%h want 0/5a00", log_cd[1], log_data[1]);
      else pass_cnt++;
    end
    $display("reset_mid: rerun pulses=%0d ws=%0d", log_cd.size(), words_sent);
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = 5'd0;
    wr_data    = 16'h0000;
    start      = 1'b0;
    cmd_word   = 16'h0000;
    abort      = 1'b0;
    force_busy = 1'b0;
    test_reset();
    test_basic();
    test_rt_transmit();
    test_count_zero();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
